// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer for the systolic array: snapshots matrix A on start, streams it in
// diagonally skewed (row i lags i cycles), then idles the inputs for a drain window.
module systolic_feed_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ARRAY_W      = 4,
    parameter int ARRAY_L      = 4,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            start,
    input  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] data_rom,
    output logic [0:ARRAY_W-1][DATA_WIDTH-1:0]              row_data,
    output logic [0:ARRAY_W-1]                              row_valid,
    output logic                                            busy,
    output logic                                            done
);

    localparam int STEP_W = $clog2(ARRAY_W + ARRAY_L);
    localparam int CNT_W  = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int ROW_IW = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1;
    localparam int COL_IW = (ARRAY_L > 1) ? $clog2(ARRAY_L) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ARRAY_W + ARRAY_L - 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } state_t;

    state_t                                          state;
    logic [STEP_W-1:0]                               step;
    logic [CNT_W-1:0]                                cnt;
    logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] snapshot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            step      <= '0;
            cnt       <= '0;
            // NOTE: the matrix copy is cleared as well, so an aborted run leaves no
            // stale operands behind that a later partial feed could expose.
            snapshot  <= '0;
            row_data  <= '0;
            row_valid <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    row_data  <= '0;
                    row_valid <= '0;
                    if (start) begin
                        snapshot <= data_rom;
                        step     <= '0;
                        busy     <= 1'b1;
                        state    <= FEED;
                    end
                end

                FEED: begin
                    // Row i carries column k = step - i while that column exists.
                    for (int i = 0; i < ARRAY_W; i++) begin
                        // NOTE: all assignments here are non-blocking, so the column hit
                        // below simply overrides this default clear on the same edge.
                        row_data[ROW_IW'(i)]  <= '0;
                        row_valid[ROW_IW'(i)] <= 1'b0;
                        for (int j = 0; j < ARRAY_L; j++) begin
                            if (step == STEP_W'(i + j)) begin
                                row_data[ROW_IW'(i)]  <= snapshot[ROW_IW'(i)][COL_IW'(j)];
                                row_valid[ROW_IW'(i)] <= 1'b1;
                            end
                        end
                    end
                    step <= step + 1'b1;
                    if (step == STEP_LAST) begin
                        if (DRAIN_CYCLES == 0) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    row_data  <= '0;
                    row_valid <= '0;
                    cnt       <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
